// File: rtl/mac_rx.sv
// mac_rx -- RMII receive MAC.
//
// Registers the PHY dibits once, hunts for a run of 01 preamble dibits followed
// by the 11 SFD, then streams the frame body downstream through a CRC_DIBITS-deep
// delay line so that the trailing FCS is never emitted. The CRC-32/BZIP2
// register (poly 04C11DB7, init FFFFFFFF, MSB-first, rxd[1] before rxd[0]) runs
// over data+FCS and must land on CRC_RESIDUE for a good frame.
//
// Optional build macro: MAC_RX_STATS_EN adds saturating good/bad frame counters.
//
// Ports:
//   clk         in   RMII 50 MHz reference clock
//   reset       in   asynchronous, active-low
//   phy_crsdv   in   RMII CRS_DV
//   phy_rxd     in   RMII receive dibit
//   axi_valid   out  axi_dout carries a payload dibit (sink always accepts)
//   axi_dout    out  payload dibit, wire order
//   frame_done  out  one-cycle pulse at the end of every reported frame
//   frame_ok    out  good-frame flag, valid with frame_done, held until next one
//   frame_len   out  payload dibits delivered, valid with frame_done
//   stat_good   out  (MAC_RX_STATS_EN) good frames seen
//   stat_bad    out  (MAC_RX_STATS_EN) bad frames plus preamble/SFD aborts
module mac_rx #(
  parameter int          MIN_PREAMBLE_DIBITS = 8,
  parameter int          CRC_DIBITS          = 16,
  parameter int          MIN_FRAME_DIBITS    = 256,
  parameter int          MAX_FRAME_DIBITS    = 6072,
  parameter logic [31:0] CRC_RESIDUE         = 32'hC704DD7B
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phy_crsdv,
  input  logic [1:0]  phy_rxd,
  output logic        axi_valid,
  output logic [1:0]  axi_dout,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [15:0] frame_len
`ifdef MAC_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_bad
`endif
);

  localparam logic [7:0]  L_MIN_PRE = 8'(MIN_PREAMBLE_DIBITS);
  localparam logic [15:0] L_CRC     = 16'(CRC_DIBITS);
  localparam logic [15:0] L_MIN     = 16'(MIN_FRAME_DIBITS);
  localparam logic [15:0] L_MAX     = 16'(MAX_FRAME_DIBITS);

  typedef enum logic [2:0] {ST_IDLE, ST_PREAMBLE, ST_DATA, ST_CHECK, ST_DROP} state_t;

  state_t                      r_state;
  logic                        r_crs_q;
  logic [1:0]                  r_rxd_q;
  logic                        r_report;
  logic [7:0]                  r_pre_cnt;
  logic [15:0]                 r_count;
  logic [15:0]                 r_out_cnt;
  logic [31:0]                 r_crc;
  logic [CRC_DIBITS-1:0][1:0]  r_dl;
  logic [1:0]                  r_pop;
  logic                        r_pop_vld;

  logic                        w_shift;
  logic [15:0]                 w_count_inc;
  logic [31:0]                 w_crc_next;
  logic                        w_len_ok;

  // One dibit of CRC-32/BZIP2, rxd[1] shifted in first.
  function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 1; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign w_shift     = (r_state == ST_DATA) && r_crs_q;
  assign w_count_inc = sat_inc(r_count);
  assign w_crc_next  = crc_dibit(r_crc, r_rxd_q);
  assign w_len_ok    = (r_count[1:0] == 2'b00) && (r_count >= L_MIN) && (r_count <= L_MAX);

  // Input stage. crs_q resets to 1 so the drop state cannot mistake the reset
  // value for the end of a frame that was already on the wire at release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_crs_q <= 1'b1;
      r_rxd_q <= 2'b00;
    end else begin
      r_crs_q <= phy_crsdv;
      r_rxd_q <= phy_rxd;
    end
  end

  // Delay line: index 0 newest, top index oldest. Whatever is left in it when
  // carrier drops is the FCS and is simply abandoned.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_dl <= '0;
    else if (w_shift) r_dl <= {r_dl[CRC_DIBITS-2:0], r_rxd_q};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_DROP;
      r_report   <= 1'b0;
      r_pre_cnt  <= '0;
      r_count    <= '0;
      r_out_cnt  <= '0;
      r_crc      <= '1;
      r_pop      <= '0;
      r_pop_vld  <= 1'b0;
      axi_valid  <= 1'b0;
      axi_dout   <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      frame_len  <= '0;
`ifdef MAC_RX_STATS_EN
      stat_good  <= '0;
      stat_bad   <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      // Popped dibit goes out one cycle later; this stage sets the 18-edge latency.
      axi_valid  <= r_pop_vld;
      axi_dout   <= r_pop;
      r_pop_vld  <= 1'b0;
      if (r_pop_vld) r_out_cnt <= r_out_cnt + 16'd1;

      case (r_state)
        ST_IDLE: begin
          if (r_crs_q) begin
            r_state   <= ST_PREAMBLE;
            r_pre_cnt <= '0;
          end
        end

        ST_PREAMBLE: begin
          if (!r_crs_q) begin
            r_state <= ST_IDLE;
          end else begin
            // A bad dibit aborts silently into drop; only the stats see it.
            if ((r_rxd_q == 2'b10) ||
                ((r_rxd_q == 2'b00) && (r_pre_cnt != 8'd0)) ||
                ((r_rxd_q == 2'b11) && (r_pre_cnt < L_MIN_PRE))) begin
              r_state  <= ST_DROP;
              r_report <= 1'b0;
`ifdef MAC_RX_STATS_EN
              stat_bad <= sat_inc(stat_bad);
`endif
            end else if (r_rxd_q == 2'b11) begin
              r_state   <= ST_DATA;
              r_crc     <= '1;
              r_count   <= '0;
              r_out_cnt <= '0;
            end else if ((r_rxd_q == 2'b01) && (r_pre_cnt != 8'hFF)) begin
              r_pre_cnt <= r_pre_cnt + 8'd1;
            end
          end
        end

        ST_DATA: begin
          if (!r_crs_q) begin
            r_state <= ST_CHECK;
          end else begin
            r_count <= w_count_inc;
            r_crc   <= w_crc_next;
            if (w_count_inc > L_MAX) begin
              r_state  <= ST_DROP;
              r_report <= 1'b1;
            end else if (r_count >= L_CRC) begin
              // Line is full: the incoming dibit pushes the oldest one out.
              r_pop     <= r_dl[CRC_DIBITS-1];
              r_pop_vld <= 1'b1;
            end
          end
        end

        ST_CHECK: begin
          frame_done <= 1'b1;
          frame_len  <= (r_count >= L_CRC) ? r_count - L_CRC : 16'd0;
          frame_ok   <= w_len_ok && (r_crc == CRC_RESIDUE);
`ifdef MAC_RX_STATS_EN
          if (w_len_ok && (r_crc == CRC_RESIDUE)) stat_good <= sat_inc(stat_good);
          else                                    stat_bad  <= sat_inc(stat_bad);
`endif
          r_state <= ST_IDLE;
        end

        ST_DROP: begin
          if (!r_crs_q) begin
            if (r_report) begin
              frame_done <= 1'b1;
              frame_ok   <= 1'b0;
              frame_len  <= r_out_cnt;
`ifdef MAC_RX_STATS_EN
              stat_bad   <= sat_inc(stat_bad);
`endif
            end
            r_report <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_rx.sv
// Testbench for mac_rx: a table of directed frames with constant expected
// results, a hand-placed asynchronous reset in the middle of one frame, then
// randomized frames whose expected status comes from a frame-level model.
module tb_mac_rx;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        phy_crsdv = 1'b0;
  logic [1:0]  phy_rxd = 2'b00;
  logic        axi_valid;
  logic [1:0]  axi_dout;
  logic        frame_done;
  logic        frame_ok;
  logic [15:0] frame_len;
`ifdef MAC_RX_STATS_EN
  logic [15:0] stat_good;
  logic [15:0] stat_bad;
  int          exp_good = 0;
  int          exp_bad  = 0;
`endif

  mac_rx dut (
    .clk        (clk),
    .reset      (reset),
    .phy_crsdv  (phy_crsdv),
    .phy_rxd    (phy_rxd),
    .axi_valid  (axi_valid),
    .axi_dout   (axi_dout),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .frame_len  (frame_len)
`ifdef MAC_RX_STATS_EN
    ,
    .stat_good  (stat_good),
    .stat_bad   (stat_bad)
`endif
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Monitor state
  logic [1:0] obs_q[$];
  int         done_ok_q[$];
  int         done_len_q[$];
  int         first_valid_cyc = -1;
  int         overlap_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (axi_valid) begin
        obs_q.push_back(axi_dout);
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (frame_done) begin
        done_ok_q.push_back(int'(frame_ok));
        done_len_q.push_back(int'(frame_len));
      end
      if (axi_valid && frame_done) overlap_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Transmit-side CRC-32/BZIP2 over a dibit stream, rxd[1] first.
  function automatic logic [31:0] crc_of(input logic [1:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 1; b >= 0; b--) begin
        if (c[31] ^ q[i][b]) c = {c[30:0], 1'b0} ^ 32'h04C11DB7;
        else                 c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Frame-level reference: what the receiver must report for a frame built
  // from `pre` preamble dibits, SFD dibit `sfd` and `total` dibits after it.
  // The first carrier dibit is spent leaving idle, so pre-1 01s are counted.
  function automatic void model(input int pre, input logic [1:0] sfd, input int total,
                                input bit crc_good, output bit done, output bit ok,
                                output int len);
    done = (sfd == 2'b11) && (pre - 1 >= 8);
    if (total > 6072)    len = 6072 - 16;
    else if (total < 16) len = 0;
    else                 len = total - 16;
    ok = done && crc_good && (total % 4 == 0) && (total >= 256) && (total <= 6072);
    if (!done) len = 0;
  endfunction

  task automatic drive(input logic crs, input logic [1:0] d);
    @(posedge clk);
    #1;
    phy_crsdv = crs;
    phy_rxd   = d;
  endtask

  task automatic run_frame(input string name, input int pre, input logic [1:0] sfd,
                           input int n_data, input bit add_fcs, input int corrupt,
                           input int rst_at, input bit exp_done, input bit exp_ok,
                           input int exp_len);
    logic [1:0]  body[$];
    logic [31:0] fcs;
    int          cap_cyc;
    int          mism;
    int          n_exp;
    body = {};
    for (int i = 0; i < n_data; i++) body.push_back(2'($urandom_range(0, 3)));
    if (add_fcs) begin
      fcs = ~crc_of(body);
      for (int k = 0; k < 16; k++) body.push_back(fcs[31-2*k -: 2]);
    end
    if (corrupt >= 0) body[corrupt] = body[corrupt] ^ 2'b01;

    obs_q.delete();
    done_ok_q.delete();
    done_len_q.delete();
    first_valid_cyc = -1;
    cap_cyc = 0;

    for (int i = 0; i < pre; i++) drive(1'b1, 2'b01);
    drive(1'b1, sfd);
    for (int i = 0; i < body.size(); i++) begin
      drive(1'b1, body[i]);
      if (i == 0) cap_cyc = cyc + 1;
      if (rst_at >= 0 && i == rst_at) begin
        reset = 1'b0;
        #1;
        check({name, " async reset axi_valid"},  int'(axi_valid),  0);
        check({name, " async reset frame_len"},  int'(frame_len),  0);
        check({name, " async reset frame_ok"},   int'(frame_ok),   0);
        obs_q.delete();
        done_ok_q.delete();
        done_len_q.delete();
        first_valid_cyc = -1;
      end
      if (rst_at >= 0 && i == rst_at + 3) reset = 1'b1;
    end
    for (int i = 0; i < 40; i++) drive(1'b0, 2'b00);

    n_exp = exp_done ? exp_len : 0;
    check({name, " frame_done count"}, done_ok_q.size(), exp_done ? 1 : 0);
    if (exp_done && done_ok_q.size() > 0) begin
      check({name, " frame_ok"},  done_ok_q[0],  int'(exp_ok));
      check({name, " frame_len"}, done_len_q[0], exp_len);
    end
    check({name, " axi_valid count"}, obs_q.size(), n_exp);
    mism = 0;
    for (int i = 0; i < obs_q.size() && i < n_exp; i++)
      if (obs_q[i] != body[i]) mism++;
    check({name, " payload mismatches"}, mism, 0);
    if (n_exp > 0 && rst_at < 0)
      check({name, " latency"}, first_valid_cyc - cap_cyc, 18);

`ifdef MAC_RX_STATS_EN
    if (rst_at >= 0)    begin exp_good = 0; exp_bad = 0; end
    else if (!exp_done) exp_bad++;
    else if (exp_ok)    exp_good++;
    else                exp_bad++;
    check({name, " stat_good"}, int'(stat_good), exp_good);
    check({name, " stat_bad"},  int'(stat_bad),  exp_bad);
`endif

    $display("frame %-12s out=%0d done=%0d ok=%0d len=%0d", name, obs_q.size(),
             done_ok_q.size(), (done_ok_q.size() > 0) ? done_ok_q[0] : 0,
             (done_len_q.size() > 0) ? done_len_q[0] : 0);
  endtask

  typedef struct {
    string      name;
    int         pre;
    logic [1:0] sfd;
    int         n_data;
    bit         add_fcs;
    int         corrupt;
    int         rst_at;
    bit         exp_done;
    bit         exp_ok;
    int         exp_len;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{"good",      32, 2'b11,  256, 1'b1, -1,  -1, 1'b1, 1'b1,  256};
    vecs[1]  = '{"bad_fcs",   32, 2'b11,  256, 1'b1, 37,  -1, 1'b1, 1'b0,  256};
    vecs[2]  = '{"short_pre",  4, 2'b11,   64, 1'b0, -1,  -1, 1'b0, 1'b0,    0};
    vecs[3]  = '{"good2",     32, 2'b11,  256, 1'b1, -1,  -1, 1'b1, 1'b1,  256};
    vecs[4]  = '{"mid_reset", 32, 2'b11,  256, 1'b1, -1, 100, 1'b0, 1'b0,    0};
    vecs[5]  = '{"after_rst", 32, 2'b11,  256, 1'b1, -1,  -1, 1'b1, 1'b1,  256};
    vecs[6]  = '{"misalign",  32, 2'b11,  242, 1'b1, -1,  -1, 1'b1, 1'b0,  242};
    vecs[7]  = '{"min_len",    9, 2'b11,  240, 1'b1, -1,  -1, 1'b1, 1'b1,  240};
    vecs[8]  = '{"too_short", 32, 2'b11,  236, 1'b1, -1,  -1, 1'b1, 1'b0,  236};
    vecs[9]  = '{"bad_sfd",   20, 2'b10,   50, 1'b0, -1,  -1, 1'b0, 1'b0,    0};
    vecs[10] = '{"tiny",      20, 2'b11,   10, 1'b0, -1,  -1, 1'b1, 1'b0,    0};
    vecs[11] = '{"max_len",   12, 2'b11, 6056, 1'b1, -1,  -1, 1'b1, 1'b1, 6056};

    // Reset state, during and after reset.
    repeat (3) @(posedge clk);
    #1;
    check("reset axi_valid",  int'(axi_valid),  0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset frame_len",  int'(frame_len),  0);
    reset = 1'b1;
    repeat (5) drive(1'b0, 2'b00);
    check("post-reset frame_ok", int'(frame_ok), 0);
`ifdef MAC_RX_STATS_EN
    check("reset stat_good", int'(stat_good), 0);
    check("reset stat_bad",  int'(stat_bad),  0);
`endif

    foreach (vecs[v])
      run_frame(vecs[v].name, vecs[v].pre, vecs[v].sfd, vecs[v].n_data, vecs[v].add_fcs,
                vecs[v].corrupt, vecs[v].rst_at, vecs[v].exp_done, vecs[v].exp_ok,
                vecs[v].exp_len);

    // Oversize frame: 6100 dibits after SFD.
    run_frame("oversize", 32, 2'b11, 6100, 1'b0, -1, -1, 1'b1, 1'b0, 6056);

    // Randomized frames against the frame-level model.
    for (int r = 0; r < 8; r++) begin
      int         pre, n_data, corrupt, len;
      logic [1:0] sfd;
      bit         add_fcs, done, ok;
      pre     = $urandom_range(10, 40);
      sfd     = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b11;
      n_data  = $urandom_range(228, 330);
      add_fcs = ($urandom_range(0, 3) != 0);
      corrupt = (add_fcs && $urandom_range(0, 2) == 0) ? $urandom_range(0, n_data - 1) : -1;
      model(pre, sfd, n_data + (add_fcs ? 16 : 0), add_fcs && corrupt < 0, done, ok, len);
      run_frame($sformatf("rand%0d", r), pre, sfd, n_data, add_fcs, corrupt, -1, done, ok, len);
    end

    check("frame_done with axi_valid", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
